shifter_pipe: RTL and testbench
===============================

SHIFTER_PIPE -- requirements
Module: shifter_pipe

Interface
REQ-001 Parameter DATA_WIDTH, default 32: operand/result width; SHALL be a power of two, 8..64.
REQ-002 Parameter STAGES, default 2: register stages; SHALL be 1..log2(DATA_WIDTH).
REQ-003 Parameter TAG_W, default 4: width of the sideband tag carried with each operation.
REQ-004 Port clk  input  1  the single clock; all state updates on its rising edge.
REQ-005 Port resetn  input  1  asynchronous, active-low reset.
REQ-006 Port in_valid  input  1  the input beat is valid.
REQ-007 Port in_ready  output  1  the block accepts the input beat this cycle.
REQ-008 Port in_a  input  DATA_WIDTH  operand to shift.
REQ-009 Port in_shamt  input  log2(DATA_WIDTH)  shift amount.
REQ-010 Port in_op  input  3  000/001 SLL, 010 SRL, 011 SRA, 100 ROL, 101 ROR, 110/111 reserved.
REQ-011 Port in_tag  input  TAG_W  sideband tag, returned unchanged.
REQ-012 Port out_valid  output  1  the output beat is valid.
REQ-013 Port out_ready  input  1  the consumer accepts the output beat.
REQ-014 Port out_result  output  DATA_WIDTH  shifted/rotated result.
REQ-015 Port out_carry  output  1  last bit shifted out (see REQ-024).
REQ-016 Port out_zero  output  1  out_result equals zero.
REQ-017 Port out_tag  output  TAG_W  tag of the beat on the output.

Function
REQ-018 Transfer SHALL occur on a cycle with valid and ready both high; input accept and output retire SHALL be independent on the same edge.
REQ-019 The datapath SHALL be log2(DATA_WIDTH) levels, level k shifting by 2^k when in_shamt[k]=1; levels SHALL be split into STAGES contiguous groups of ceil(log2(DATA_WIDTH)/STAGES) levels each (last group may be shorter), each group ending in a register slice.
REQ-020 Each slice SHALL hold valid, partial data, remaining shamt bits, op, tag and running carry; latency from accept to out_valid SHALL be exactly STAGES cycles with no stall.
REQ-021 Slice i SHALL load when it is empty or slice i+1 (or the consumer for the last slice) takes its content that cycle; in_ready SHALL equal that load condition for slice 0; full throughput of one beat per cycle SHALL be sustained while out_ready=1.
REQ-022 When out_ready=0 and out_valid=1, out_result, out_carry, out_zero and out_tag SHALL hold stable until retired; no beat SHALL be dropped or duplicated.
REQ-023 SRA SHALL fill with in_a[DATA_WIDTH-1]; SRL and SLL SHALL fill with 0; ROL/ROR SHALL wrap modulo DATA_WIDTH.
REQ-024 out_carry: SLL = in_a[DATA_WIDTH-shamt]; SRL/SRA = in_a[shamt-1]; ROL = out_result[0]; ROR = out_result[DATA_WIDTH-1]; SHALL be 0 whenever shamt=0.
REQ-025 Reserved ops SHALL pass in_a unchanged with out_carry=0.
REQ-026 out_zero SHALL be computed from the final result, registered in the last slice.
REQ-027 Bubbles (slice empty) SHALL not affect held data; data registers of empty slices are don't-care but out_* of a non-valid output SHALL NOT be checked.

Reset
REQ-028 On resetn=0, all slice valid bits SHALL clear immediately (asynchronously): out_valid=0, out_result=0, out_carry=0, out_zero=0, out_tag=0.
REQ-029 During reset in_ready SHALL be 0; on the first clock edge after resetn rises the pipeline SHALL be empty and in_ready=1.
REQ-030 Reset asserted mid-operation SHALL discard all in-flight beats; none SHALL appear after release.

Verification (DATA_WIDTH=32, STAGES=2, TAG_W=4)
REQ-031 Accept a=0x80000001, shamt=1, op=SRA, tag=3, out_ready=1 -> 2 cycles later out_valid=1, result=0xC0000000, carry=1, zero=0, tag=3.
REQ-032 Back-to-back ROL a=0x80000000 shamt=1, ROR a=0x00000001 shamt=4, SLL a=0xFFFFFFFF shamt=0 -> consecutive outputs 0x00000001/c=1, 0x10000000/c=0, 0xFFFFFFFF/c=0, one per cycle.
REQ-033 Stream 5 beats with out_ready=0 for 4 cycles -> in_ready drops after 2 accepts, output holds first beat stable, all 5 retire in order once out_ready=1.
REQ-034 SLL a=0x00000001 shamt=31 then SRL same a shamt=1 -> 0x80000000/c=0/z=0 then 0x00000000/c=1/z=1.
REQ-035 Assert resetn=0 with 2 beats in flight -> out_valid=0 immediately; after release no stale beat emerges and the next accepted beat returns after 2 cycles.
REQ-036 op=110, a=0x12345678, shamt=7 -> result 0x12345678, carry=0.

Source files
------------

// File: rtl/shifter_pipe_if.sv
// Handshake bundle for shifter_pipe: an input beat (operand, shift amount,
// operation, tag) and an output beat (result, carry, zero, tag), each
// qualified by its own valid/ready pair.
interface shifter_pipe_if #(
    parameter int DATA_WIDTH = 32,
    parameter int TAG_W      = 4
);
    localparam int SHAMT_W = $clog2(DATA_WIDTH);

    logic                  in_valid;
    logic                  in_ready;
    logic [DATA_WIDTH-1:0] in_a;
    logic [SHAMT_W-1:0]    in_shamt;
    logic [2:0]            in_op;
    logic [TAG_W-1:0]      in_tag;
    logic                  out_valid;
    logic                  out_ready;
    logic [DATA_WIDTH-1:0] out_result;
    logic                  out_carry;
    logic                  out_zero;
    logic [TAG_W-1:0]      out_tag;

    // Producer/consumer side: issues operations and accepts results.
    modport master (
        output in_valid, in_a, in_shamt, in_op, in_tag, out_ready,
        input  in_ready, out_valid, out_result, out_carry, out_zero, out_tag
    );

    // Shifter side.
    modport slave (
        input  in_valid, in_a, in_shamt, in_op, in_tag, out_ready,
        output in_ready, out_valid, out_result, out_carry, out_zero, out_tag
    );
endinterface

// File: rtl/shifter_pipe.sv
// Pipelined barrel shifter/rotator. The log2(DATA_WIDTH) shift levels are
// split into STAGES contiguous groups, each closed by a register slice with
// valid/ready flow control so a stalled consumer backs up the whole pipe
// without dropping or duplicating beats.
module shifter_pipe #(
    parameter int DATA_WIDTH = 32,
    parameter int STAGES     = 2,
    parameter int TAG_W      = 4
) (
    input  logic          clk,
    input  logic          resetn,
    shifter_pipe_if.slave bus
);
    localparam int SHAMT_W       = $clog2(DATA_WIDTH);
    localparam int LEVELS        = SHAMT_W;
    localparam int LVL_PER_STAGE = (LEVELS + STAGES - 1) / STAGES;

    typedef enum logic [2:0] {
        OP_SLL     = 3'b000,
        OP_SLL_ALT = 3'b001,
        OP_SRL     = 3'b010,
        OP_SRA     = 3'b011,
        OP_ROL     = 3'b100,
        OP_ROR     = 3'b101,
        OP_RSV0    = 3'b110,
        OP_RSV1    = 3'b111
    } op_e;

    // Everything a beat needs to finish its journey through the remaining levels.
    typedef struct packed {
        logic                  valid;
        logic [DATA_WIDTH-1:0] data;
        logic [SHAMT_W-1:0]    shamt;
        op_e                   op;
        logic [TAG_W-1:0]      tag;
        logic                  carry;
        logic                  zero;
    } slice_t;

    // Applies shift levels [lo, hi) to a beat. The running carry is taken from
    // the partial value before each active level: composing the levels, the bit
    // leaving at the last active level is exactly in_a[W-shamt] (left ops) or
    // in_a[shamt-1] (right ops), which for rotates equals result[0]/result[W-1].
    // A shamt of zero never activates a level, so carry stays 0.
    function automatic slice_t apply_levels(input slice_t s, input int lo, input int hi);
        slice_t             r;
        int                 n;
        logic [SHAMT_W-1:0] lidx;
        logic [SHAMT_W-1:0] ridx;
        r = s;
        for (int k = 0; k < LEVELS; k++) begin
            n    = 1 << k;
            lidx = SHAMT_W'(DATA_WIDTH - n);
            ridx = SHAMT_W'(n - 1);
            if (k >= lo && k < hi && s.shamt[k]) begin
                case (r.op)
                    OP_SLL, OP_SLL_ALT: begin
                        r.carry = r.data[lidx];
                        r.data  = r.data << n;
                    end
                    OP_SRL: begin
                        r.carry = r.data[ridx];
                        r.data  = r.data >> n;
                    end
                    OP_SRA: begin
                        r.carry = r.data[ridx];
                        r.data  = DATA_WIDTH'($signed(r.data) >>> n);
                    end
                    OP_ROL: begin
                        r.carry = r.data[lidx];
                        r.data  = (r.data << n) | (r.data >> (DATA_WIDTH - n));
                    end
                    OP_ROR: begin
                        r.carry = r.data[ridx];
                        r.data  = (r.data >> n) | (r.data << (DATA_WIDTH - n));
                    end
                    default: ;  // reserved ops pass the operand through, carry 0
                endcase
            end
        end
        return r;
    endfunction

    slice_t in_beat;

    // Pack the incoming bus beat into slice form.
    always_comb begin
        // NOTE: every always_comb output gets a full default first so no path leaves it unassigned (no latch).
        in_beat       = '0;
        in_beat.valid = bus.in_valid;
        in_beat.data  = bus.in_a;
        in_beat.shamt = bus.in_shamt;
        in_beat.op    = op_e'(bus.in_op);
        in_beat.tag   = bus.in_tag;
    end

    for (genvar s = 0; s < STAGES; s++) begin : g_slice
        localparam int LO = s * LVL_PER_STAGE;
        localparam int HI = (LO + LVL_PER_STAGE > LEVELS) ? LEVELS : LO + LVL_PER_STAGE;

        slice_t src;
        slice_t d;
        slice_t q;
        logic   ld;

        if (s == 0) begin : g_head
            assign src = in_beat;
        end else begin : g_body
            assign src = g_slice[s-1].q;
        end

        // A slice loads when empty or when its content moves on this cycle.
        if (s == STAGES - 1) begin : g_tail
            logic unused_tail;
            assign ld          = !q.valid || bus.out_ready;
            assign unused_tail = ^{q.shamt, q.op};
        end else begin : g_mid
            assign ld = !q.valid || g_slice[s+1].ld;
        end

        // Shift through this group's levels; the last slice also derives the zero flag.
        always_comb begin
            d = apply_levels(src, LO, HI);
            if (s == STAGES - 1) begin
                d.zero = (d.data == '0);
            end
        end

        // Slice register: capture when loading, otherwise hold.
        always_ff @(posedge clk or negedge resetn) begin
            if (!resetn) begin
                // NOTE: the data fields are reset too, not just valid, because the outputs must read zero during reset.
                q <= '0;
            end else if (ld) begin
                // NOTE: non-blocking so every slice samples its upstream neighbour's pre-edge value.
                q <= d;
            end
        end
    end

    assign bus.in_ready   = g_slice[0].ld & resetn;
    assign bus.out_valid  = g_slice[STAGES-1].q.valid;
    assign bus.out_result = g_slice[STAGES-1].q.data;
    assign bus.out_carry  = g_slice[STAGES-1].q.carry;
    assign bus.out_zero   = g_slice[STAGES-1].q.zero;
    assign bus.out_tag    = g_slice[STAGES-1].q.tag;
endmodule

// File: tb/tb_shifter_pipe.sv
// Directed bench for shifter_pipe (DATA_WIDTH=32, STAGES=2, TAG_W=4).
// Inputs change and outputs are sampled on the falling clock edge.
module tb_shifter_pipe;
    localparam int W  = 32;
    localparam int TW = 4;

    localparam logic [2:0] SLL  = 3'b000;
    localparam logic [2:0] SLL1 = 3'b001;
    localparam logic [2:0] SRL  = 3'b010;
    localparam logic [2:0] SRA  = 3'b011;
    localparam logic [2:0] ROL  = 3'b100;
    localparam logic [2:0] ROR  = 3'b101;
    localparam logic [2:0] RSV6 = 3'b110;
    localparam logic [2:0] RSV7 = 3'b111;

    // {valid, result, carry, zero, tag}
    typedef logic [W+TW+2:0] beat_t;

    logic clk;
    logic resetn;
    int   n_cmp = 0;
    int   n_bad = 0;

    shifter_pipe_if #(.DATA_WIDTH(W), .TAG_W(TW)) bus ();

    shifter_pipe #(.DATA_WIDTH(W), .STAGES(2), .TAG_W(TW)) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    beat_t obs;
    assign obs = {bus.out_valid, bus.out_result, bus.out_carry, bus.out_zero, bus.out_tag};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic beat_t mk(input logic [W-1:0] r, input logic c, input logic z,
                                 input logic [TW-1:0] t);
        return {1'b1, r, c, z, t};
    endfunction

    task automatic drive(input logic v, input logic [W-1:0] a, input logic [4:0] sh,
                         input logic [2:0] op, input logic [TW-1:0] tag);
        bus.in_valid = v;
        bus.in_a     = a;
        bus.in_shamt = sh;
        bus.in_op    = op;
        bus.in_tag   = tag;
    endtask

    task automatic idle();
        drive(1'b0, '0, 5'd0, 3'd0, '0);
    endtask

    task automatic test_reset();
        resetn        = 1'b0;
        bus.out_ready = 1'b0;
        idle();
        repeat (2) @(negedge clk);
        n_cmp++;
        if (obs !== '0) begin
            n_bad++; $display("FAIL reset_outputs: got %h want %h", obs, beat_t'(0));
        end
        n_cmp++;
        if (bus.in_ready !== 1'b0) begin
            n_bad++; $display("FAIL reset_in_ready: got %b want 0", bus.in_ready);
        end
        @(negedge clk);
        resetn = 1'b1;
        @(posedge clk);
        #1;
        n_cmp++;
        if (bus.in_ready !== 1'b1) begin
            n_bad++; $display("FAIL post_reset_in_ready: got %b want 1", bus.in_ready);
        end
        n_cmp++;
        if (bus.out_valid !== 1'b0) begin
            n_bad++; $display("FAIL post_reset_out_valid: got %b want 0", bus.out_valid);
        end
    endtask

    task automatic test_sra();
        beat_t want;
        want = mk(32'hC000_0000, 1'b1, 1'b0, 4'd3);
        @(negedge clk);
        bus.out_ready = 1'b1;
        drive(1'b1, 32'h8000_0001, 5'd1, SRA, 4'd3);
        #1;
        n_cmp++;
        if (bus.in_ready !== 1'b1) begin
            n_bad++; $display("FAIL sra_in_ready: got %b want 1", bus.in_ready);
        end
        @(negedge clk);
        idle();
        n_cmp++;
        if (bus.out_valid !== 1'b0) begin
            n_bad++; $display("FAIL sra_latency_1: got %b want 0", bus.out_valid);
        end
        @(negedge clk);
        n_cmp++;
        if (obs !== want) begin
            n_bad++; $display("FAIL sra_result: got %h want %h", obs, want);
        end
    endtask

    task automatic test_back_to_back();
        logic [W-1:0]  a_v [3];
        logic [4:0]    s_v [3];
        logic [2:0]    o_v [3];
        logic [TW-1:0] t_v [3];
        beat_t         e_v [3];
        a_v = '{32'h8000_0000, 32'h0000_0001, 32'hFFFF_FFFF};
        s_v = '{5'd1, 5'd4, 5'd0};
        o_v = '{ROL, ROR, SLL};
        t_v = '{4'd1, 4'd2, 4'd7};
        e_v = '{mk(32'h0000_0001, 1'b1, 1'b0, 4'd1),
                mk(32'h1000_0000, 1'b0, 1'b0, 4'd2),
                mk(32'hFFFF_FFFF, 1'b0, 1'b0, 4'd7)};
        bus.out_ready = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            n_cmp++;
            if (c >= 2 && c <= 4) begin
                if (obs !== e_v[c-2]) begin
                    n_bad++; $display("FAIL b2b_beat%0d: got %h want %h", c - 2, obs, e_v[c-2]);
                end
            end else if (bus.out_valid !== 1'b0) begin
                n_bad++; $display("FAIL b2b_idle_c%0d: got valid %b want 0", c, bus.out_valid);
            end
            if (c < 3) drive(1'b1, a_v[c], s_v[c], o_v[c], t_v[c]);
            else idle();
        end
    endtask

    task automatic test_stall();
        logic [W-1:0]  a_v [5];
        logic [4:0]    s_v [5];
        logic [2:0]    o_v [5];
        logic [TW-1:0] t_v [5];
        beat_t         e_v [5];
        int            sent;
        int            got;
        a_v = '{32'h0000_00F0, 32'h0000_00F0, 32'hF000_0000, 32'h0000_00FF, 32'h0000_000F};
        s_v = '{5'd4, 5'd5, 5'd8, 5'd8, 5'd4};
        o_v = '{SLL, SRL, SRA, ROR, SRL};
        t_v = '{4'd1, 4'd2, 4'd4, 4'd5, 4'd6};
        e_v = '{mk(32'h0000_0F00, 1'b0, 1'b0, 4'd1),
                mk(32'h0000_0007, 1'b1, 1'b0, 4'd2),
                mk(32'hFFF0_0000, 1'b0, 1'b0, 4'd4),
                mk(32'hFF00_0000, 1'b1, 1'b0, 4'd5),
                mk(32'h0000_0000, 1'b1, 1'b1, 4'd6)};
        sent = 0;
        got  = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (bus.out_valid === 1'b1) begin
                n_cmp++;
                if (got >= 5) begin
                    n_bad++; $display("FAIL stall_extra_beat: got %h want no beat", obs);
                end else if (obs !== e_v[got]) begin
                    n_bad++; $display("FAIL stall_beat%0d_c%0d: got %h want %h", got, c, obs, e_v[got]);
                end
            end
            bus.out_ready = (c >= 4);
            if (sent < 5) drive(1'b1, a_v[sent], s_v[sent], o_v[sent], t_v[sent]);
            else idle();
            #1;
            if (c < 4) begin
                n_cmp++;
                if (bus.in_ready !== (c < 2)) begin
                    n_bad++; $display("FAIL stall_in_ready_c%0d: got %b want %b", c, bus.in_ready, c < 2);
                end
            end
            if (bus.out_valid === 1'b1 && bus.out_ready) got++;
            if (bus.in_valid && bus.in_ready === 1'b1) sent++;
        end
        n_cmp++;
        if (got != 5) begin
            n_bad++; $display("FAIL stall_retired: got %0d want 5", got);
        end
        n_cmp++;
        if (sent != 5) begin
            n_bad++; $display("FAIL stall_accepted: got %0d want 5", sent);
        end
    endtask

    task automatic test_boundary();
        logic [W-1:0]  a_v [8];
        logic [4:0]    s_v [8];
        logic [2:0]    o_v [8];
        beat_t         e_v [8];
        a_v = '{32'h0000_0001, 32'h0000_0001, 32'h1234_5678, 32'hDEAD_BEEF,
                32'h1234_5678, 32'h8000_0001, 32'h4000_0000, 32'h0000_0003};
        s_v = '{5'd31, 5'd1, 5'd7, 5'd31, 5'd4, 5'd0, 5'd31, 5'd1};
        o_v = '{SLL, SRL, RSV6, RSV7, SLL1, ROL, SRA, ROR};
        e_v = '{mk(32'h8000_0000, 1'b0, 1'b0, 4'd0),
                mk(32'h0000_0000, 1'b1, 1'b1, 4'd1),
                mk(32'h1234_5678, 1'b0, 1'b0, 4'd2),
                mk(32'hDEAD_BEEF, 1'b0, 1'b0, 4'd3),
                mk(32'h2345_6780, 1'b1, 1'b0, 4'd4),
                mk(32'h8000_0001, 1'b0, 1'b0, 4'd5),
                mk(32'h0000_0000, 1'b1, 1'b1, 4'd6),
                mk(32'h8000_0001, 1'b1, 1'b0, 4'd7)};
        bus.out_ready = 1'b1;
        for (int c = 0; c < 11; c++) begin
            @(negedge clk);
            if (c >= 2) begin
                n_cmp++;
                if (c <= 9 && obs !== e_v[c-2]) begin
                    n_bad++; $display("FAIL edge_vec%0d: got %h want %h", c - 2, obs, e_v[c-2]);
                end else if (c > 9 && bus.out_valid !== 1'b0) begin
                    n_bad++; $display("FAIL edge_drain: got valid %b want 0", bus.out_valid);
                end
            end
            if (c < 8) drive(1'b1, a_v[c], s_v[c], o_v[c], 4'(c));
            else idle();
        end
    endtask

    task automatic test_reset_midflight();
        beat_t want;
        want = mk(32'h0000_0001, 1'b0, 1'b0, 4'd11);
        bus.out_ready = 1'b1;
        @(negedge clk);
        drive(1'b1, 32'h0000_00FF, 5'd4, SLL, 4'd9);
        @(negedge clk);
        drive(1'b1, 32'h0000_0F00, 5'd4, SRL, 4'd10);
        @(negedge clk);
        idle();
        n_cmp++;
        if (bus.out_valid !== 1'b1) begin
            n_bad++; $display("FAIL midflight_pre_reset: got valid %b want 1", bus.out_valid);
        end
        resetn = 1'b0;
        #1;
        n_cmp++;
        if (obs !== '0) begin
            n_bad++; $display("FAIL midflight_async_clear: got %h want %h", obs, beat_t'(0));
        end
        n_cmp++;
        if (bus.in_ready !== 1'b0) begin
            n_bad++; $display("FAIL midflight_in_ready: got %b want 0", bus.in_ready);
        end
        @(negedge clk);
        resetn = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            n_cmp++;
            if (bus.out_valid !== 1'b0) begin
                n_bad++; $display("FAIL midflight_stale_c%0d: got valid %b want 0", c, bus.out_valid);
            end
        end
        drive(1'b1, 32'h0000_0080, 5'd7, SRL, 4'd11);
        @(negedge clk);
        idle();
        n_cmp++;
        if (bus.out_valid !== 1'b0) begin
            n_bad++; $display("FAIL midflight_latency_1: got valid %b want 0", bus.out_valid);
        end
        @(negedge clk);
        n_cmp++;
        if (obs !== want) begin
            n_bad++; $display("FAIL midflight_new_beat: got %h want %h", obs, want);
        end
    endtask

    initial begin
        test_reset();
        test_sra();
        test_back_to_back();
        test_stall();
        test_boundary();
        test_reset_midflight();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1, "watchdog expired");
    end
endmodule
